// File: rtl/fifo_wr_arbiter_pkg.sv
// ==== fifo_arb_pkg : shared types and helpers for the FIFO write arbiter (rev 1.0) ====
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Elaboration-time ceil(log2(v)), also used by the FIFO blocks
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
// ==== fifo_wr_arbiter_if : producer/FIFO write-side bundle of the arbiter (rev 1.0) ====
`default_nettype none

interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int OW = clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic [WIDTH-1:0]      fifo_data;
  logic [OW-1:0]         owner;
  logic                  busy;

  modport master (
    output req, data_in, fifo_full,
    input  gnt, fifo_wr, fifo_data, owner, busy
  );

  modport slave (
    input  req, data_in, fifo_full,
    output gnt, fifo_wr, fifo_data, owner, busy
  );

endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ==== rr_pick : rotating priority encoder, first request after i_last (rev 1.0) ====
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int OW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [OW-1:0]   i_last,
  output logic            o_valid,
  output logic [OW-1:0]   o_idx
);

  logic [OW-1:0] w_pos;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = OW'((int'(i_last) + k) % NREQ);
      if (!o_valid && i_req[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ==== fifo_wr_arbiter : round-robin burst arbiter for one FIFO write port (rev 1.0) ====
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int OW = clog2(NREQ);
  localparam int CW = clog2(BURST + 1);

  state_t          r_state, w_state_nx;
  logic [OW-1:0]   r_last, w_last_nx;
  logic [OW-1:0]   r_owner, w_owner_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [NREQ-1:0] w_gnt_c, w_gnt;
  logic [WIDTH-1:0] w_data;
  logic            w_pick_vld;
  logic [OW-1:0]   w_pick;

  rr_pick #(.NREQ(NREQ), .OW(OW)) u_pick (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_valid(w_pick_vld),
    .o_idx  (w_pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= OW'(NREQ - 1);
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_last  <= w_last_nx;
      r_owner <= w_owner_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_last_nx  = r_last;
    w_owner_nx = r_owner;
    w_cnt_nx   = r_cnt;
    w_gnt_c    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld && !bus.fifo_full) begin
          w_gnt_c[w_pick] = 1'b1;
          w_owner_nx      = w_pick;
          w_cnt_nx        = CW'(1);
          if (BURST == 1) w_last_nx  = w_pick;
          else            w_state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.req[r_owner]) begin
          // a full FIFO simply stalls the burst; nothing advances
          if (!bus.fifo_full) begin
            w_gnt_c[r_owner] = 1'b1;
            w_cnt_nx         = r_cnt + CW'(1);
            if (r_cnt == CW'(BURST - 1)) begin
              w_last_nx  = r_owner;
              w_state_nx = ST_IDLE;
            end
          end
        end else begin
          w_last_nx  = r_owner;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // grant path is combinational, so it must also be masked by the async reset
  assign w_gnt = rst_n ? w_gnt_c : '0;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_data = w_data | bus.data_in[i*WIDTH +: WIDTH];
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.fifo_wr   = |w_gnt;
  assign bus.fifo_data = w_data;
  assign bus.owner     = r_owner;
  assign bus.busy      = (r_state == ST_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ==== tb_fifo_wr_arbiter : directed self-checking bench for fifo_wr_arbiter (rev 1.0) ====
`default_nettype none

module tb_fifo_wr_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fifo_wr_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .BURST(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, d1, d2, d3);
    bus.data_in = {d3, d2, d1, d0};
  endtask

  // Hold reset with all requests up, check outputs, release just after an edge
  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req       = 4'b1111;
    bus.fifo_full = 1'b0;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    @(negedge clk);
    check("rst_gnt",   32'(bus.gnt),       32'h0);
    check("rst_wr",    32'(bus.fifo_wr),   32'h0);
    check("rst_data",  32'(bus.fifo_data), 32'h0);
    check("rst_owner", 32'(bus.owner),     32'h0);
    check("rst_busy",  32'(bus.busy),      32'h0);
    next_cyc();
    rst_n   = 1'b1;
    bus.req = 4'b0000;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.data_in   = '0;
    bus.fifo_full = 1'b0;

    // 1+2: single producer 2, continuous bursts with a one-cycle busy dip
    do_reset();
    bus.req = 4'b0100;
    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t2_gnt",  32'(bus.gnt),       32'h4);
      check("t2_wr",   32'(bus.fifo_wr),   32'h1);
      check("t2_data", 32'(bus.fifo_data), 32'hA5);
      check("t2_busy", 32'(bus.busy),      (k % 4 != 0) ? 32'h1 : 32'h0);
      next_cyc();
    end

    // 3: all four requesting, bursts of 4 rotate 0,1,2,3,0
    do_reset();
    bus.req = 4'b1111;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t3_data", 32'(bus.fifo_data), 32'h10 + 32'((k / 4) % 4));
      check("t3_gnt",  32'(bus.gnt),       32'(1 << ((k / 4) % 4)));
      next_cyc();
    end

    // 4: producer 1 stalled by full after word 2
    do_reset();
    bus.req = 4'b0010;
    set_data(8'h00, 8'h3C, 8'h00, 8'h00);
    for (int k = 0; k < 7; k++) begin
      bus.fifo_full = (k >= 2 && k <= 4);
      @(negedge clk);
      check("t4_gnt", 32'(bus.gnt),     (k >= 2 && k <= 4) ? 32'h0 : 32'h2);
      check("t4_wr",  32'(bus.fifo_wr), (k >= 2 && k <= 4) ? 32'h0 : 32'h1);
      if (k > 0) check("t4_owner", 32'(bus.owner), 32'h1);
      next_cyc();
    end
    bus.fifo_full = 1'b0;
    bus.req       = 4'b0000;
    @(negedge clk);
    check("t4_rel_gnt",   32'(bus.gnt),   32'h0);
    check("t4_rel_owner", 32'(bus.owner), 32'h1);
    next_cyc();

    // 5: producer 0 drops after two words, one idle cycle, then producer 1
    do_reset();
    bus.req = 4'b0011;
    set_data(8'h20, 8'h21, 8'h00, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t5_gnt0", 32'(bus.gnt), 32'h1);
      next_cyc();
    end
    bus.req = 4'b0010;
    @(negedge clk);
    check("t5_gap", 32'(bus.gnt), 32'h0);
    next_cyc();
    @(negedge clk);
    check("t5_gnt1",  32'(bus.gnt),       32'h2);
    check("t5_data1", 32'(bus.fifo_data), 32'h21);
    next_cyc();
    @(negedge clk);
    check("t5_owner", 32'(bus.owner), 32'h1);
    next_cyc();

    // 6: reset asserted during producer 2's third word
    do_reset();
    bus.req = 4'b0100;
    set_data(8'h00, 8'h00, 8'h77, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_gnt", 32'(bus.gnt), 32'h4);
      if (k < 2) next_cyc();
    end
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_gnt",  32'(bus.gnt),     32'h0);
    check("t6_async_wr",   32'(bus.fifo_wr), 32'h0);
    check("t6_async_busy", 32'(bus.busy),    32'h0);
    next_cyc();
    bus.req = 4'b0101;
    set_data(8'h55, 8'h00, 8'h77, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_first_gnt",  32'(bus.gnt),       32'h1);
    check("t6_first_data", 32'(bus.fifo_data), 32'h55);
    next_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
